// File: rtl/gerenciador_vez.sv
// Turn controller for tic-tac-toe: drives the player-turn display code,
// alternates turns on valid moves, enforces a per-turn timeout and holds
// the error code for a fixed time after an invalid move or a timeout.
module gerenciador_vez #(
  parameter int unsigned TIMEOUT_CICLOS = 5000,
  parameter int unsigned ERRO_CICLOS    = 1000,
  parameter int unsigned LARGURA_CONT   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_valida,
  input  logic       jogada_invalida,
  input  logic       fim_jogo,
  output logic [1:0] jogador,
  output logic       vez_ativa,
  output logic       troca_vez,
  output logic       timeout
);

  localparam logic [1:0] COD_NADA = 2'b00;
  localparam logic [1:0] COD_J1   = 2'b01;
  localparam logic [1:0] COD_J2   = 2'b10;
  localparam logic [1:0] COD_ERRO = 2'b11;

  localparam logic [LARGURA_CONT-1:0] CONT_TIMEOUT = LARGURA_CONT'(TIMEOUT_CICLOS - 1);
  localparam logic [LARGURA_CONT-1:0] CONT_ERRO    = LARGURA_CONT'(ERRO_CICLOS - 1);
  localparam logic [LARGURA_CONT-1:0] CONT_MAX     = '1;

  typedef enum logic [2:0] {
    OCIOSO,
    VEZ_J1,
    VEZ_J2,
    ERRO,
    FIM
  } estado_t;

  estado_t                 estado, estado_prox;
  logic [LARGURA_CONT-1:0] cont, cont_prox, cont_inc;
  // retorno_j2: turn to resume after ERRO (0 = P1, 1 = P2)
  logic                    retorno_j2, retorno_j2_prox;
  // troca_pend: the pending ERRO exit hands the turn to the other player
  logic                    troca_pend, troca_pend_prox;
  logic [1:0]              jogador_prox;
  logic                    vez_ativa_prox, troca_vez_prox, timeout_prox;

  // Saturating increment of the shared cycle counter
  assign cont_inc = (cont == CONT_MAX) ? cont : cont + LARGURA_CONT'(1);

  // State, counter and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= OCIOSO;
      cont       <= '0;
      retorno_j2 <= 1'b0;
      troca_pend <= 1'b0;
      jogador    <= COD_NADA;
      vez_ativa  <= 1'b0;
      troca_vez  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      estado     <= estado_prox;
      cont       <= cont_prox;
      retorno_j2 <= retorno_j2_prox;
      troca_pend <= troca_pend_prox;
      jogador    <= jogador_prox;
      vez_ativa  <= vez_ativa_prox;
      troca_vez  <= troca_vez_prox;
      timeout    <= timeout_prox;
    end
  end

  // Next state, counter update and next output values
  always_comb begin
    estado_prox     = estado;
    cont_prox       = cont;
    retorno_j2_prox = retorno_j2;
    troca_pend_prox = troca_pend;
    troca_vez_prox  = 1'b0;
    timeout_prox    = 1'b0;
    jogador_prox    = COD_NADA;
    vez_ativa_prox  = 1'b0;

    case (estado)
      OCIOSO, FIM: begin
        if (iniciar) estado_prox = VEZ_J1;
      end
      VEZ_J1, VEZ_J2: begin
        cont_prox = cont_inc;
        if (fim_jogo) begin
          estado_prox = FIM;
        end else if (jogada_valida) begin
          estado_prox    = (estado == VEZ_J1) ? VEZ_J2 : VEZ_J1;
          troca_vez_prox = 1'b1;
        end else if (jogada_invalida) begin
          estado_prox     = ERRO;
          retorno_j2_prox = (estado == VEZ_J2);
          troca_pend_prox = 1'b0;
        end else if (cont == CONT_TIMEOUT) begin
          estado_prox     = ERRO;
          retorno_j2_prox = (estado == VEZ_J1);
          troca_pend_prox = 1'b1;
          timeout_prox    = 1'b1;
        end
      end
      ERRO: begin
        cont_prox = cont_inc;
        if (fim_jogo) begin
          estado_prox = FIM;
        end else if (cont == CONT_ERRO) begin
          estado_prox    = retorno_j2 ? VEZ_J2 : VEZ_J1;
          troca_vez_prox = troca_pend;
        end
      end
      default: estado_prox = OCIOSO;
    endcase

    // Every state change restarts the counter
    if (estado_prox != estado) cont_prox = '0;

    case (estado_prox)
      VEZ_J1: begin
        jogador_prox   = COD_J1;
        vez_ativa_prox = 1'b1;
      end
      VEZ_J2: begin
        jogador_prox   = COD_J2;
        vez_ativa_prox = 1'b1;
      end
      ERRO:    jogador_prox = COD_ERRO;
      default: jogador_prox = COD_NADA;
    endcase
  end

endmodule

// File: tb/tb_gerenciador_vez.sv
// Scoreboard bench for gerenciador_vez with short timer parameters.
// Observed word layout: {jogador[1:0], vez_ativa, troca_vez, timeout}.
module tb_gerenciador_vez;

  localparam int unsigned TIMEOUT_CICLOS = 20;
  localparam int unsigned ERRO_CICLOS    = 4;
  localparam int unsigned LARGURA_CONT   = 8;

  // Stimulus word: {iniciar, jogada_valida, jogada_invalida, fim_jogo}
  localparam logic [3:0] S_NADA = 4'b0000;
  localparam logic [3:0] S_INI  = 4'b1000;
  localparam logic [3:0] S_VAL  = 4'b0100;
  localparam logic [3:0] S_INV  = 4'b0010;
  localparam logic [3:0] S_FIM  = 4'b0001;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, jogada_valida, jogada_invalida, fim_jogo;
  logic [1:0] jogador;
  logic       vez_ativa, troca_vez, timeout;

  int n_chk  = 0;
  int n_fail = 0;

  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];

  gerenciador_vez #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS),
    .ERRO_CICLOS   (ERRO_CICLOS),
    .LARGURA_CONT  (LARGURA_CONT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .jogada_valida  (jogada_valida),
    .jogada_invalida(jogada_invalida),
    .fim_jogo       (fim_jogo),
    .jogador        (jogador),
    .vez_ativa      (vez_ativa),
    .troca_vez      (troca_vez),
    .timeout        (timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [4:0] ex(input logic [1:0] jog, input logic vez,
                                    input logic tr, input logic tm);
    return {jog, vez, tr, tm};
  endfunction

  function automatic logic [4:0] obs();
    return {jogador, vez_ativa, troca_vez, timeout};
  endfunction

  // Drive one cycle of stimulus, queue its expected result, record the DUT output
  task automatic aplicar(input logic [3:0] s, input logic [4:0] e);
    {iniciar, jogada_valida, jogada_invalida, fim_jogo} = s;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    obs_q.push_back(obs());
    {iniciar, jogada_valida, jogada_invalida, fim_jogo} = S_NADA;
  endtask

  task automatic test_reset();
    logic [4:0] got, esp;
    int idx = 0;
    reset = 1'b1;
    {iniciar, jogada_valida, jogada_invalida, fim_jogo} = S_NADA;
    #1 reset = 1'b0;
    #2;
    n_chk++;
    if (obs() !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_estado: got %b required 00000", obs());
    end
    @(negedge clock) reset = 1'b1;
    for (int i = 0; i < 5; i++) aplicar(S_NADA, ex(2'b00, 1'b0, 1'b0, 1'b0));
    aplicar(S_VAL, ex(2'b00, 1'b0, 1'b0, 1'b0));
    aplicar(S_INI, ex(2'b01, 1'b1, 1'b0, 1'b0));
    while (exp_q.size() != 0) begin
      esp = exp_q.pop_front();
      got = obs_q.pop_front();
      idx++;
      n_chk++;
      if (got !== esp) begin
        n_fail++;
        $display("FAIL reset_inicio passo %0d: got %b required %b", idx, got, esp);
      end
    end
  endtask

  task automatic test_alternancia();
    logic [4:0] got, esp;
    int idx = 0;
    aplicar(S_VAL,  ex(2'b10, 1'b1, 1'b1, 1'b0));
    aplicar(S_NADA, ex(2'b10, 1'b1, 1'b0, 1'b0));
    aplicar(S_VAL,  ex(2'b01, 1'b1, 1'b1, 1'b0));
    aplicar(S_NADA, ex(2'b01, 1'b1, 1'b0, 1'b0));
    aplicar(S_VAL,  ex(2'b10, 1'b1, 1'b1, 1'b0));
    aplicar(S_NADA, ex(2'b10, 1'b1, 1'b0, 1'b0));
    while (exp_q.size() != 0) begin
      esp = exp_q.pop_front();
      got = obs_q.pop_front();
      idx++;
      n_chk++;
      if (got !== esp) begin
        n_fail++;
        $display("FAIL alternancia passo %0d: got %b required %b", idx, got, esp);
      end
    end
  endtask

  // P2 errs: error code held ERRO_CICLOS cycles, moves ignored, P2 resumes
  task automatic test_invalida();
    logic [4:0] got, esp;
    int idx = 0;
    aplicar(S_INV,  ex(2'b11, 1'b0, 1'b0, 1'b0));
    aplicar(S_VAL,  ex(2'b11, 1'b0, 1'b0, 1'b0));
    aplicar(S_INV,  ex(2'b11, 1'b0, 1'b0, 1'b0));
    aplicar(S_NADA, ex(2'b11, 1'b0, 1'b0, 1'b0));
    aplicar(S_NADA, ex(2'b10, 1'b1, 1'b0, 1'b0));
    while (exp_q.size() != 0) begin
      esp = exp_q.pop_front();
      got = obs_q.pop_front();
      idx++;
      n_chk++;
      if (got !== esp) begin
        n_fail++;
        $display("FAIL invalida passo %0d: got %b required %b", idx, got, esp);
      end
    end
  endtask

  // P1 idles out: timeout at entry+TIMEOUT_CICLOS, error, then P2 with troca_vez
  task automatic test_timeout();
    logic [4:0] got, esp;
    int idx = 0;
    aplicar(S_VAL, ex(2'b01, 1'b1, 1'b1, 1'b0));
    for (int i = 1; i < int'(TIMEOUT_CICLOS); i++)
      aplicar((i == 7) ? S_INI : S_NADA, ex(2'b01, 1'b1, 1'b0, 1'b0));
    aplicar(S_NADA, ex(2'b11, 1'b0, 1'b0, 1'b1));
    for (int i = 1; i < int'(ERRO_CICLOS); i++)
      aplicar(S_NADA, ex(2'b11, 1'b0, 1'b0, 1'b0));
    aplicar(S_NADA, ex(2'b10, 1'b1, 1'b1, 1'b0));
    aplicar(S_NADA, ex(2'b10, 1'b1, 1'b0, 1'b0));
    while (exp_q.size() != 0) begin
      esp = exp_q.pop_front();
      got = obs_q.pop_front();
      idx++;
      n_chk++;
      if (got !== esp) begin
        n_fail++;
        $display("FAIL timeout passo %0d: got %b required %b", idx, got, esp);
      end
    end
  endtask

  task automatic test_prioridade();
    logic [4:0] got, esp;
    int idx = 0;
    aplicar(S_VAL | S_INV, ex(2'b01, 1'b1, 1'b1, 1'b0));
    aplicar(S_VAL | S_FIM, ex(2'b00, 1'b0, 1'b0, 1'b0));
    aplicar(S_VAL,         ex(2'b00, 1'b0, 1'b0, 1'b0));
    aplicar(S_INV,         ex(2'b00, 1'b0, 1'b0, 1'b0));
    aplicar(S_INI,         ex(2'b01, 1'b1, 1'b0, 1'b0));
    aplicar(S_INV,         ex(2'b11, 1'b0, 1'b0, 1'b0));
    aplicar(S_FIM | S_VAL, ex(2'b00, 1'b0, 1'b0, 1'b0));
    aplicar(S_INI,         ex(2'b01, 1'b1, 1'b0, 1'b0));
    while (exp_q.size() != 0) begin
      esp = exp_q.pop_front();
      got = obs_q.pop_front();
      idx++;
      n_chk++;
      if (got !== esp) begin
        n_fail++;
        $display("FAIL prioridade passo %0d: got %b required %b", idx, got, esp);
      end
    end
  endtask

  task automatic test_reset_assincrono();
    logic [4:0] got, esp;
    int idx = 0;
    aplicar(S_INV, ex(2'b11, 1'b0, 1'b0, 1'b0));
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if (obs() !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_assincrono: got %b required 00000", obs());
    end
    @(negedge clock) reset = 1'b1;
    aplicar(S_NADA, ex(2'b00, 1'b0, 1'b0, 1'b0));
    aplicar(S_INI,  ex(2'b01, 1'b1, 1'b0, 1'b0));
    aplicar(S_NADA, ex(2'b01, 1'b1, 1'b0, 1'b0));
    while (exp_q.size() != 0) begin
      esp = exp_q.pop_front();
      got = obs_q.pop_front();
      idx++;
      n_chk++;
      if (got !== esp) begin
        n_fail++;
        $display("FAIL reset_retomada passo %0d: got %b required %b", idx, got, esp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alternancia();
    test_invalida();
    test_timeout();
    test_prioridade();
    test_reset_assincrono();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
